// File: rtl/synth_pkg.sv
// Shared types and widths for the voice scheduler slice: phase/note widths,
// scheduler FSM states and the per-voice table entry.
package synth_pkg;

  localparam int PHASE_W = 32;
  localparam int NOTE_W  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    SEARCH = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic              active;
    logic [NOTE_W-1:0] note;
    logic [PHASE_W-1:0] delta;
  } voice_entry_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// Event handshake from the note decoder and the per-voice stream to the
// phase accumulator. slave = scheduler side, master = driver/monitor side.
interface voice_scheduler_if;
  import synth_pkg::*;

  logic               ev_valid;
  logic               ev_ready;
  logic               ev_note_on;
  logic [NOTE_W-1:0]  ev_note;
  logic [PHASE_W-1:0] ev_delta;
  logic [7:0]         voice_index;
  logic [PHASE_W-1:0] delta_phase;
  logic               voice_valid;
  logic               sweep_done;

  modport slave (
    input  ev_valid, ev_note_on, ev_note, ev_delta,
    output ev_ready, voice_index, delta_phase, voice_valid, sweep_done
  );

  modport master (
    output ev_valid, ev_note_on, ev_note, ev_delta,
    input  ev_ready, voice_index, delta_phase, voice_valid, sweep_done
  );

endinterface

// File: rtl/voice_table.sv
// Per-voice register file: one registered sweep read port (idle voices read
// as zero delta), one combinational search compare port, one write port.
module voice_table
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int AW         = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [PHASE_W-1:0] rd_delta,
  input  logic [AW-1:0]      cmp_slot,
  input  logic               cmp_on,
  input  logic [NOTE_W-1:0]  cmp_note,
  output logic               cmp_hit,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  voice_entry_t       wr_entry
);

  voice_entry_t tbl [NUM_VOICES];

  // table write: note-on loads the whole entry, note-off only clears active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      if (wr_entry.active) tbl[wr_addr] <= wr_entry;
      else                 tbl[wr_addr].active <= 1'b0;
    end
  end

  // sweep read port: retained delta of a released voice is masked to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        rd_delta <= '0;
    else if (rd_en && tbl[rd_addr].active) rd_delta <= tbl[rd_addr].delta;
    else                                 rd_delta <= '0;
  end

  // search compare: free slot for note-on, sounding matching note for note-off
  always_comb begin
    cmp_hit = 1'b0;
    if (cmp_on) cmp_hit = !tbl[cmp_slot].active;
    else        cmp_hit = tbl[cmp_slot].active && (tbl[cmp_slot].note == cmp_note);
  end

endmodule

// File: rtl/voice_scheduler.sv
// Voice allocator and sweep sequencer feeding the dds phase accumulator.
// Optional build macro VOICE_SCHED_STEAL_EN: a note-on with no free slot
// evicts a round-robin victim instead of being dropped.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  voice_scheduler_if.slave  bus,
  output logic              ev_dropped,
  output logic              sweep_overrun
);

  localparam int AW = $clog2(NUM_VOICES);
  typedef logic [AW:0]   ptr_t;
  typedef logic [AW-1:0] slot_t;
  localparam ptr_t NV   = ptr_t'(NUM_VOICES);
  localparam ptr_t LAST = ptr_t'(NUM_VOICES - 1);

  state_t             state, state_nx;
  ptr_t               ptr;          // sweep: next voice to emit; search: slot under test
  logic               tick_pend;
  logic               alive;        // holds ev_ready low until the first edge out of reset
  logic               ev_on_q;
  logic [NOTE_W-1:0]  ev_note_q;
  logic [PHASE_W-1:0] ev_delta_q;
  slot_t              slot_q;       // slot chosen for COMMIT
  slot_t              victim;

  logic       ev_ready_c, start_sweep, accept, rd_en, wr_en, miss_on;
  slot_t      rd_addr;
  logic       cmp_hit;
  logic [7:0] voice_index_q;
  logic       voice_valid_q, sweep_done_q;

`ifdef VOICE_SCHED_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
  slot_t steal_ptr;

  // round-robin victim pointer, advanced on every eviction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    steal_ptr <= '0;
    else if (miss_on) steal_ptr <= (steal_ptr == slot_t'(NUM_VOICES - 1)) ? '0 : steal_ptr + slot_t'(1);
  end

  assign victim = steal_ptr;
`else
  localparam bit STEAL_EN = 1'b0;
  assign victim = '0;
`endif

  voice_table #(.NUM_VOICES(NUM_VOICES), .AW(AW)) u_table (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_delta (bus.delta_phase),
    .cmp_slot (ptr[AW-1:0]),
    .cmp_on   (ev_on_q),
    .cmp_note (ev_note_q),
    .cmp_hit  (cmp_hit),
    .wr_en    (wr_en),
    .wr_addr  (slot_q),
    .wr_entry ('{active: ev_on_q, note: ev_note_q, delta: ev_delta_q})
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state: tick beats events in IDLE; a miss either evicts or returns
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_sweep) state_nx = SWEEP;
               else if (accept) state_nx = SEARCH;
      SWEEP:   if (ptr == NV) state_nx = IDLE;
      SEARCH:  if (cmp_hit) state_nx = COMMIT;
               else if (ptr == LAST) state_nx = (ev_on_q && STEAL_EN) ? COMMIT : IDLE;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: handshake, table read/write strobes, search miss
  always_comb begin
    ev_ready_c  = 1'b0;
    start_sweep = 1'b0;
    accept      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    miss_on     = 1'b0;
    case (state)
      IDLE: begin
        start_sweep = sample_tick || tick_pend;
        ev_ready_c  = alive && !start_sweep;
        accept      = ev_ready_c && bus.ev_valid;
        rd_en       = start_sweep;
      end
      SWEEP: begin
        rd_en   = (ptr != NV);
        rd_addr = ptr[AW-1:0];
      end
      SEARCH:  miss_on = !cmp_hit && (ptr == LAST) && ev_on_q;
      COMMIT:  wr_en = 1'b1;
      default: ;
    endcase
  end

  // datapath: pointers, latched event, pending tick and registered pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      tick_pend     <= 1'b0;
      alive         <= 1'b0;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_delta_q    <= '0;
      slot_q        <= '0;
      voice_index_q <= '0;
      voice_valid_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      sweep_overrun <= 1'b0;
      ev_dropped    <= 1'b0;
    end else begin
      alive         <= 1'b1;
      voice_valid_q <= rd_en;
      voice_index_q <= rd_en ? 8'(rd_addr) : 8'd0;
      sweep_done_q  <= (state == SWEEP) && (ptr == NV);
      sweep_overrun <= (state == SWEEP) && sample_tick;
      ev_dropped    <= miss_on && !STEAL_EN;
      if ((state == SEARCH || state == COMMIT) && sample_tick) tick_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start_sweep) begin
            ptr       <= ptr_t'(1);   // voice 0 is read on this edge
            tick_pend <= 1'b0;
          end else if (accept) begin
            ptr        <= '0;
            ev_on_q    <= bus.ev_note_on;
            ev_note_q  <= bus.ev_note;
            ev_delta_q <= bus.ev_delta;
          end
        end
        SWEEP:  if (ptr != NV) ptr <= ptr + ptr_t'(1);
        SEARCH: begin
          slot_q <= cmp_hit ? ptr[AW-1:0] : victim;
          if (!cmp_hit) ptr <= ptr + ptr_t'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ev_ready    = ev_ready_c;
  assign bus.voice_index = voice_index_q;
  assign bus.voice_valid = voice_valid_q;
  assign bus.sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler (NUM_VOICES=16).
module tb_voice_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  logic sample_tick;
  logic ev_dropped, sweep_overrun;

  voice_scheduler_if bus();

  voice_scheduler #(.NUM_VOICES(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .bus           (bus),
    .ev_dropped    (ev_dropped),
    .sweep_overrun (sweep_overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        drop_seen;
  logic [31:0] exp_d [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_d[i] = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sample_tick = 1'b0;
    bus.ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // drive one event, then wait for the scheduler to return to IDLE
  task automatic ev(input logic on, input logic [6:0] note, input logic [31:0] d);
    int n = 0;
    drop_seen = 1'b0;
    bus.ev_valid = 1'b1; bus.ev_note_on = on; bus.ev_note = note; bus.ev_delta = d;
    while (!bus.ev_ready && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.ev_valid = 1'b0;
    while (!bus.ev_ready && n < 300) begin drop_seen |= ev_dropped; @(negedge clk); n++; end
    drop_seen |= ev_dropped;
    chk("event timeout", 64'(n >= 300), 64'd0);
  endtask

  // called on the negedge of the first expected valid cycle
  task automatic check_sweep(input string tag, input int inj);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s v%0d", tag, i),
          {23'd0, bus.voice_valid, bus.voice_index, bus.delta_phase},
          {23'd0, 1'b1, 8'(i), exp_d[i]});
      if (i == inj) sample_tick = 1'b1;
      if (inj >= 0 && i == inj + 1) begin
        sample_tick = 1'b0;
        chk("overrun pulse", 64'(sweep_overrun), 64'd1);
      end
      @(negedge clk);
    end
    chk({tag, " done"}, {62'd0, bus.voice_valid, bus.sweep_done}, 64'd1);
    @(negedge clk);
    chk({tag, " idle"}, {62'd0, bus.voice_valid, bus.sweep_done}, 64'd0);
  endtask

  task automatic do_sweep(input string tag, input int inj);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check_sweep(tag, inj);
  endtask

  initial begin
    reset_n = 1'b0; sample_tick = 1'b0;
    bus.ev_valid = 1'b0; bus.ev_note_on = 1'b0; bus.ev_note = '0; bus.ev_delta = '0;

    // 1: reset values, then an empty sweep
    @(negedge clk);
    chk("reset ev_ready", 64'(bus.ev_ready), 64'd0);
    chk("reset outputs", {22'd0, bus.voice_valid, bus.sweep_done, ev_dropped, sweep_overrun,
        bus.voice_index, bus.delta_phase}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", 64'(bus.ev_ready), 64'd1);
    clear_exp();
    do_sweep("empty", -1);

    // 2: single note-on lands in voice 0
    ev(1'b1, 7'd60, 32'h0123_4567);
    exp_d[0] = 32'h0123_4567;
    do_sweep("one", -1);

    // 3: note-off frees a middle slot, refilled by the next note-on
    do_reset(); clear_exp();
    ev(1'b1, 7'd60, 32'h100);
    ev(1'b1, 7'd64, 32'h200);
    ev(1'b1, 7'd67, 32'h300);
    ev(1'b0, 7'd64, 32'h0);
    chk("off no drop", 64'(drop_seen), 64'd0);
    ev(1'b0, 7'd61, 32'h0);
    chk("unmatched off no drop", 64'(drop_seen), 64'd0);
    exp_d[0] = 32'h100; exp_d[2] = 32'h300;
    do_sweep("off", -1);
    ev(1'b1, 7'd72, 32'h400);
    exp_d[1] = 32'h400;
    do_sweep("refill", -1);

    // 4: table full, 17th and 18th note-on
    do_reset(); clear_exp();
    for (int i = 0; i < 16; i++) begin
      ev(1'b1, 7'(40 + i), 32'h10 + i);
      exp_d[i] = 32'h10 + i;
    end
    ev(1'b1, 7'd90, 32'hABCD);
`ifdef VOICE_SCHED_STEAL_EN
    chk("steal no drop", 64'(drop_seen), 64'd0);
    exp_d[0] = 32'hABCD;
`else
    chk("full drop", 64'(drop_seen), 64'd1);
`endif
    ev(1'b1, 7'd91, 32'hBCDE);
`ifdef VOICE_SCHED_STEAL_EN
    chk("steal2 no drop", 64'(drop_seen), 64'd0);
    exp_d[1] = 32'hBCDE;
`else
    chk("full drop 2", 64'(drop_seen), 64'd1);
`endif
    do_sweep("full", -1);

    // 5: tick during a 16-slot search is deferred past COMMIT + one IDLE
    do_reset(); clear_exp();
    for (int i = 0; i < 15; i++) begin
      ev(1'b1, 7'(20 + i), 32'h100 + i);
      exp_d[i] = 32'h100 + i;
    end
    bus.ev_valid = 1'b1; bus.ev_note_on = 1'b1; bus.ev_note = 7'd99; bus.ev_delta = 32'h5555;
    @(negedge clk);
    bus.ev_valid = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (15) @(negedge clk);
    chk("pend commit no valid", 64'(bus.voice_valid), 64'd0);
    @(negedge clk);
    chk("pend idle no valid", 64'(bus.voice_valid), 64'd0);
    chk("pend idle not ready", 64'(bus.ev_ready), 64'd0);
    @(negedge clk);
    exp_d[15] = 32'h5555;
    check_sweep("pending", -1);

    // 6: overrun tick mid-sweep, then async reset mid-sweep
    do_reset(); clear_exp();
    ev(1'b1, 7'd50, 32'h777);
    exp_d[0] = 32'h777;
    do_sweep("overrun", 4);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid sweep valid", 64'(bus.voice_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("async reset valid", 64'(bus.voice_valid), 64'd0);
    chk("async reset outputs", {24'd0, bus.voice_index, bus.delta_phase}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_exp();
    do_sweep("after reset", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
